// File: rtl/qspi_flash_read_controller_pkg.sv
// rtl/qspi_flash_read_controller_pkg.sv - shared types and constants for the QSPI fast-read controller
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_CS_HOLD,
    ST_CS_GAP
  } state_t;

  localparam logic [7:0] CMD_QUAD_OUTPUT_READ = 8'h6B;
  localparam logic [7:0] CMD_READ             = 8'h03;

  localparam int CMD_BITS        = 8;
  localparam int NIBBLES_PER_BYTE = 2;

endpackage

// File: rtl/qspi_flash_read_controller_if.sv
// rtl/qspi_flash_read_controller_if.sv - request/response byte-stream bundle between core and controller
interface qspi_flash_read_controller_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len_m1;
  logic              resp_valid;
  logic              resp_ready;
  logic [7:0]        resp_data;
  logic              resp_last;

  modport master (
    output req_valid, req_addr, req_len_m1, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_last
  );

  modport slave (
    input  req_valid, req_addr, req_len_m1, resp_ready,
    output req_ready, resp_valid, resp_data, resp_last
  );
endinterface

// File: rtl/qspi_flash_read_controller_sclk_gen.sv
// rtl/qspi_flash_read_controller_sclk_gen.sv - SCLK half-period counter with rise/fall/sample strobes
module qspi_sclk_gen #(
  parameter int HALF_PERIOD = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic stall,
  output logic sck,
  output logic rise,
  output logic fall,
  output logic sample
);
  localparam int CNT_W = $clog2(HALF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             half_done;

  assign half_done = (cnt == CNT_MAX);
  // A stall only blocks the rising edge, so SCLK always parks low.
  assign rise   = run && !sck && half_done && !stall;
  assign fall   = run && sck && half_done;
  assign sample = run && sck && half_done;

  always_ff @(posedge clock) begin
    if (reset || !run) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (rise || fall) begin
      cnt <= '0;
      sck <= !sck;
    end else if (!half_done) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/qspi_flash_read_controller.sv
// rtl/qspi_flash_read_controller.sv - quad-output fast-read (0x6B) sequencer with backpressured byte stream
module qspi_flash_read_controller
  import qspi_pkg::*;
#(
  parameter int HALF_PERIOD    = 5,
  parameter int DUMMY_CYCLES   = 6,
  parameter int ADDR_W         = 24,
  parameter int LEN_W          = 8,
  parameter int CS_IDLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  qspi_flash_read_controller_if.slave bus,
  output logic       busy,
  output logic       qspi_cs,
  output logic       qspi_sck,
  output logic [3:0] qspi_dq_o,
  output logic [3:0] qspi_dq_oe,
  input  logic [3:0] qspi_dq_i
);
  localparam int SH_W    = CMD_BITS + ADDR_W;
  localparam int BIT_CW  = $clog2(CMD_BITS + ADDR_W + DUMMY_CYCLES);
  localparam int WAIT_CW = $clog2(HALF_PERIOD + CS_IDLE_CYCLES + 1);
  localparam logic [BIT_CW-1:0]  CMD_LAST   = BIT_CW'(CMD_BITS - 1);
  localparam logic [BIT_CW-1:0]  ADDR_LAST  = BIT_CW'(ADDR_W - 1);
  localparam logic [BIT_CW-1:0]  DUMMY_LAST = BIT_CW'(DUMMY_CYCLES - 1);
  localparam logic [WAIT_CW-1:0] HOLD_LAST  = WAIT_CW'(HALF_PERIOD - 1);
  localparam logic [WAIT_CW-1:0] GAP_LAST   = WAIT_CW'(CS_IDLE_CYCLES - 1);

  state_t             state;
  logic [SH_W-1:0]    sh;
  logic [BIT_CW-1:0]  bit_cnt;
  logic [WAIT_CW-1:0] wait_cnt;
  logic [LEN_W-1:0]   byte_cnt;
  logic               nib_sel;
  logic [3:0]         hi_nib;
  logic               run, stall, rise, fall, sample, byte_done;

  assign run = (state == ST_CS_SETUP) || (state == ST_CMD) || (state == ST_ADDR) ||
               (state == ST_DUMMY) || (state == ST_DATA);
  // Hold SCLK low before the nibble that would complete a byte while the last one is unconsumed.
  assign stall     = (state == ST_DATA) && nib_sel && bus.resp_valid && !bus.resp_ready;
  assign byte_done = (state == ST_DATA) && sample && nib_sel;

  qspi_sclk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_sclk (
    .clock  (clock),
    .reset  (reset),
    .run    (run),
    .stall  (stall),
    .sck    (qspi_sck),
    .rise   (rise),
    .fall   (fall),
    .sample (sample)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      bus.req_ready  <= 1'b1;
      busy           <= 1'b0;
      qspi_cs        <= 1'b1;
      qspi_dq_o      <= 4'b0000;
      qspi_dq_oe     <= 4'b0000;
      bus.resp_valid <= 1'b0;
      bus.resp_last  <= 1'b0;
      bus.resp_data  <= 8'h00;
      sh             <= '0;
      bit_cnt        <= '0;
      wait_cnt       <= '0;
      byte_cnt       <= '0;
      nib_sel        <= 1'b0;
      hi_nib         <= 4'h0;
    end else begin
      if (byte_done) begin
        bus.resp_valid <= 1'b1;
        bus.resp_data  <= {hi_nib, qspi_dq_i};
        bus.resp_last  <= (byte_cnt == '0);
      end else if (bus.resp_valid && bus.resp_ready) begin
        bus.resp_valid <= 1'b0;
        bus.resp_last  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            state         <= ST_CS_SETUP;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            qspi_cs       <= 1'b0;
            sh            <= {CMD_QUAD_OUTPUT_READ, bus.req_addr};
            qspi_dq_o     <= {3'b000, CMD_QUAD_OUTPUT_READ[7]};
            qspi_dq_oe    <= 4'b0001;
            byte_cnt      <= bus.req_len_m1;
          end
        end
        ST_CS_SETUP: begin
          if (rise) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
          end
        end
        ST_CMD, ST_ADDR: begin
          if (fall) begin
            sh        <= sh << 1;
            qspi_dq_o <= {3'b000, sh[SH_W-2]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (state == ST_CMD && bit_cnt == CMD_LAST) begin
              state   <= ST_ADDR;
              bit_cnt <= '0;
            end else if (state == ST_ADDR && bit_cnt == ADDR_LAST) begin
              state      <= ST_DUMMY;
              bit_cnt    <= '0;
              qspi_dq_o  <= 4'b0000;
              qspi_dq_oe <= 4'b0000;
            end
          end
        end
        ST_DUMMY: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == DUMMY_LAST) begin
              state   <= ST_DATA;
              nib_sel <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (sample) begin
            if (!nib_sel) begin
              hi_nib  <= qspi_dq_i;
              nib_sel <= 1'b1;
            end else begin
              nib_sel  <= 1'b0;
              byte_cnt <= byte_cnt - 1'b1;
              if (byte_cnt == '0) begin
                state    <= ST_CS_HOLD;
                wait_cnt <= '0;
              end
            end
          end
        end
        ST_CS_HOLD: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == HOLD_LAST) begin
            state    <= ST_CS_GAP;
            qspi_cs  <= 1'b1;
            wait_cnt <= '0;
          end
        end
        ST_CS_GAP: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == GAP_LAST) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
